// File: rtl/bcd_countdown_timer_pkg.sv
// Package timer_pkg: shared types, limits and BCD helpers for the mm:ss countdown timer.
//   timer_state_e   : 3-bit state code, also driven out as actualState
//   bcd_pair_t      : one two-digit BCD field (tens, units)
//   mmss_t          : minutes and seconds as two BCD pairs
//   bcd_inc_wrap    : +1 on a 00..59 BCD pair, 59 wraps to 00 with no carry out
//   mmss_dec        : -1 second on a full mm:ss value, BCD borrow through all four digits
//   mmss_is_zero    : true when the value is 00:00
package timer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RUN   = 3'd1,
    ST_PAUSE = 3'd2,
    ST_DONE  = 3'd3
  } timer_state_e;

  localparam logic [3:0] MAX_TENS  = 4'd5;
  localparam logic [3:0] MAX_UNITS = 4'd9;

  localparam int unsigned DEFAULT_TICK_DIV = 100_000_000;

  typedef struct packed {
    logic [3:0] tens;
    logic [3:0] units;
  } bcd_pair_t;

  typedef struct packed {
    bcd_pair_t mins;
    bcd_pair_t secs;
  } mmss_t;

  function automatic bcd_pair_t bcd_inc_wrap(bcd_pair_t p);
    bcd_pair_t r;
    r = p;
    if (p.units >= MAX_UNITS) begin
      r.units = 4'd0;
      r.tens  = (p.tens >= MAX_TENS) ? 4'd0 : p.tens + 4'd1;
    end else begin
      r.units = p.units + 4'd1;
    end
    return r;
  endfunction

  function automatic mmss_t mmss_dec(mmss_t t);
    mmss_t r;
    r = t;
    if (t.secs.units != 4'd0) begin
      r.secs.units = t.secs.units - 4'd1;
    end else begin
      r.secs.units = MAX_UNITS;
      if (t.secs.tens != 4'd0) begin
        r.secs.tens = t.secs.tens - 4'd1;
      end else begin
        r.secs.tens = MAX_TENS;
        if (t.mins.units != 4'd0) begin
          r.mins.units = t.mins.units - 4'd1;
        end else begin
          r.mins.units = MAX_UNITS;
          // Only reachable from 00:00, which the timer never decrements; wrap keeps BCD legal.
          r.mins.tens  = (t.mins.tens != 4'd0) ? t.mins.tens - 4'd1 : MAX_TENS;
        end
      end
    end
    return r;
  endfunction

  function automatic logic mmss_is_zero(mmss_t t);
    return (t == '0);
  endfunction

endpackage

// File: rtl/bcd_countdown_timer_if.sv
// Request/display bundle between the control source and the countdown timer.
//   start, pause, clear, inc_min, inc_sec : request inputs to the timer
//   mDecimal, mUnit, sDecimal, sUnit      : BCD digits of mm:ss
//   actualState                           : 0 IDLE, 1 RUN, 2 PAUSE, 3 DONE
//   finish                                : high while in DONE
// master: request source / display consumer. slave: the timer.
interface bcd_countdown_timer_if;
  logic       start;
  logic       pause;
  logic       clear;
  logic       inc_min;
  logic       inc_sec;
  logic [3:0] mDecimal;
  logic [3:0] mUnit;
  logic [3:0] sDecimal;
  logic [3:0] sUnit;
  logic [2:0] actualState;
  logic       finish;

  modport master (
    output start, pause, clear, inc_min, inc_sec,
    input  mDecimal, mUnit, sDecimal, sUnit, actualState, finish
  );

  modport slave (
    input  start, pause, clear, inc_min, inc_sec,
    output mDecimal, mUnit, sDecimal, sUnit, actualState, finish
  );
endinterface

// File: rtl/bcd_countdown_timer_tick_prescaler.sv
// tick_prescaler: free counter 0..TICK_DIV-1 that advances while enabled.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   en_i          : count this cycle
//   clr_i         : synchronous return to 0, overrides en_i
//   tick_o        : high for the enabled cycle in which the counter sits at TICK_DIV-1
// The counter holds its value while disabled so a paused partial second is kept.
module tick_prescaler #(
  parameter int unsigned TICK_DIV = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic en_i,
  input  logic clr_i,
  output logic tick_o
);

  localparam int unsigned CntW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(TICK_DIV - 1);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            at_last;

  assign at_last = (cnt_q == LastCnt);
  assign tick_o  = en_i & at_last;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = at_last ? '0 : cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/bcd_countdown_timer.sv
// bcd_countdown_timer: mm:ss preset and once-per-second BCD countdown for the VGA path.
//   clk_100MHz : system clock
//   rst_n      : asynchronous active-low reset, release synchronised internally (2 flops)
//   bus        : bcd_countdown_timer_if.slave - requests in, registered digits/state/finish out
// Parameter TICK_DIV: clock cycles per one-second tick.
// Build option TIMER_EDGE_DETECT_EN: when defined, each request passes through a 2-flop
// synchroniser and rising-edge detector (one request per held level, 3 cycles latency);
// otherwise requests are taken as single-cycle pulses every cycle they are high.
// Per-cycle request priority: clear > start > pause > inc_min/inc_sec.
module bcd_countdown_timer
  import timer_pkg::*;
#(
  parameter int unsigned TICK_DIV = DEFAULT_TICK_DIV
) (
  input  logic                 clk_100MHz,
  input  logic                 rst_n,
  bcd_countdown_timer_if.slave bus
);

  // Reset: assert immediately, release two clocks later.
  logic [1:0] rst_sync_q;
  logic       rst_int_n;

  always_ff @(posedge clk_100MHz or negedge rst_n) begin
    if (!rst_n) begin
      rst_sync_q <= 2'b00;
    end else begin
      rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
  end

  assign rst_int_n = rst_sync_q[1];

  // Request conditioning. Bit order: clear, start, pause, inc_min, inc_sec.
  logic [4:0] req_raw;
  logic [4:0] req;

  assign req_raw = {bus.clear, bus.start, bus.pause, bus.inc_min, bus.inc_sec};

`ifdef TIMER_EDGE_DETECT_EN
  logic [4:0] sync1_q, sync2_q, prev_q;

  always_ff @(posedge clk_100MHz or negedge rst_int_n) begin
    if (!rst_int_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
    end else begin
      sync1_q <= req_raw;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign req = sync2_q & ~prev_q;
`else
  assign req = req_raw;
`endif

  logic clear_req, start_req, pause_req, inc_min_req, inc_sec_req;

  assign clear_req   = req[4];
  assign start_req   = req[3];
  assign pause_req   = req[2];
  assign inc_min_req = req[1];
  assign inc_sec_req = req[0];

  // State and datapath.
  timer_state_e state_q, state_d;
  mmss_t        preset_q, preset_d;
  mmss_t        count_q, count_d;
  mmss_t        disp_q, disp_d;
  logic         finish_q, finish_d;
  logic         presc_clr;
  logic         tick;

  tick_prescaler #(
    .TICK_DIV (TICK_DIV)
  ) u_prescaler (
    .clk_i  (clk_100MHz),
    .rst_ni (rst_int_n),
    .en_i   (state_q == ST_RUN),
    .clr_i  (presc_clr),
    .tick_o (tick)
  );

  // Next-state and datapath update.
  always_comb begin
    state_d   = state_q;
    preset_d  = preset_q;
    count_d   = count_q;
    presc_clr = 1'b0;

    if (clear_req) begin
      state_d   = ST_IDLE;
      presc_clr = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_req) begin
            if (!mmss_is_zero(preset_q)) begin
              count_d   = preset_q;
              presc_clr = 1'b1;
              state_d   = ST_RUN;
            end
          end else if (!pause_req) begin
            if (inc_sec_req) preset_d.secs = bcd_inc_wrap(preset_q.secs);
            if (inc_min_req) preset_d.mins = bcd_inc_wrap(preset_q.mins);
          end
        end
        ST_RUN: begin
          if (tick) begin
            count_d = mmss_dec(count_q);
          end
          // Reaching 00:00 beats a simultaneous pause; start outranks (and drops) pause.
          if (tick && mmss_is_zero(count_d)) begin
            state_d = ST_DONE;
          end else if (pause_req && !start_req) begin
            state_d = ST_PAUSE;
          end
        end
        ST_PAUSE: begin
          if (start_req || pause_req) begin
            state_d = ST_RUN;
          end
        end
        ST_DONE: begin
          if (start_req) begin
            count_d   = preset_q;
            presc_clr = 1'b1;
            state_d   = ST_RUN;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // Registered outputs follow the next state so they move on the causing edge.
  always_comb begin
    disp_d   = (state_d == ST_IDLE) ? preset_d : count_d;
    finish_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk_100MHz or negedge rst_int_n) begin
    if (!rst_int_n) begin
      state_q  <= ST_IDLE;
      preset_q <= '0;
      count_q  <= '0;
      disp_q   <= '0;
      finish_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      preset_q <= preset_d;
      count_q  <= count_d;
      disp_q   <= disp_d;
      finish_q <= finish_d;
    end
  end

  assign bus.mDecimal    = disp_q.mins.tens;
  assign bus.mUnit       = disp_q.mins.units;
  assign bus.sDecimal    = disp_q.secs.tens;
  assign bus.sUnit       = disp_q.secs.units;
  assign bus.actualState = state_q;
  assign bus.finish      = finish_q;

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Self-checking bench for bcd_countdown_timer with TICK_DIV=4: a hand-computed vector
// table, directed multi-cycle sequences, and random requests against an integer-seconds model.
module tb_bcd_countdown_timer;

  localparam int unsigned TickDiv = 4;

  logic clk_100MHz = 1'b0;
  logic rst_n;

  always #5 clk_100MHz = ~clk_100MHz;

  bcd_countdown_timer_if bus ();

  bcd_countdown_timer #(
    .TICK_DIV (TickDiv)
  ) dut (
    .clk_100MHz (clk_100MHz),
    .rst_n      (rst_n),
    .bus        (bus)
  );

  int checks   = 0;
  int failures = 0;

  // Model: preset as minutes/seconds, count as total seconds, phase = cycles into the second.
  int m_st, m_pmin, m_psec, m_cnt, m_phase;

  typedef struct {
    logic s, p, c, im, is;
    int   mm, ss, st;
    logic fin;
  } vec_t;

  vec_t tbl [18];

  task automatic model_reset();
    m_st = 0; m_pmin = 0; m_psec = 0; m_cnt = 0; m_phase = 0;
  endtask

  task automatic model_step(input logic s, input logic p, input logic c,
                            input logic im, input logic is);
    bit ticked;
    if (c) begin
      m_st = 0;
      m_phase = 0;
    end else begin
      case (m_st)
        0: begin
          if (s) begin
            if (m_pmin * 60 + m_psec != 0) begin
              m_cnt = m_pmin * 60 + m_psec;
              m_phase = 0;
              m_st = 1;
            end
          end else if (!p) begin
            if (is) m_psec = (m_psec + 1) % 60;
            if (im) m_pmin = (m_pmin + 1) % 60;
          end
        end
        1: begin
          ticked = (m_phase == TickDiv - 1);
          m_phase = (m_phase + 1) % TickDiv;
          if (ticked) m_cnt = m_cnt - 1;
          if (ticked && m_cnt == 0) m_st = 3;
          else if (p && !s) m_st = 2;
        end
        2: if (s || p) m_st = 1;
        default: begin
          if (s) begin
            m_cnt = m_pmin * 60 + m_psec;
            m_phase = 0;
            m_st = 1;
          end
        end
      endcase
    end
  endtask

  function automatic logic [19:0] pack(input int mm, input int ss, input int st, input logic fin);
    return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10), 3'(st), fin};
  endfunction

  function automatic logic [19:0] model_out();
    if (m_st == 0) return pack(m_pmin, m_psec, 0, 1'b0);
    return pack(m_cnt / 60, m_cnt % 60, m_st, m_st == 3);
  endfunction

  function automatic logic [19:0] dut_out();
    return {bus.mDecimal, bus.mUnit, bus.sDecimal, bus.sUnit, bus.actualState, bus.finish};
  endfunction

  task automatic check(input string name, input logic [19:0] got, input logic [19:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h%0h:%0h%0h state=%0d finish=%0b, expected %0h%0h:%0h%0h state=%0d finish=%0b",
               name, got[19:16], got[15:12], got[11:8], got[7:4], got[3:1], got[0],
               exp[19:16], exp[15:12], exp[11:8], exp[7:4], exp[3:1], exp[0]);
    end
  endtask

  // One clock with the given requests; outputs compared with the model 1 time unit later.
  task automatic cyc(input logic s, input logic p, input logic c, input logic im, input logic is);
    bus.start = s; bus.pause = p; bus.clear = c; bus.inc_min = im; bus.inc_sec = is;
    @(posedge clk_100MHz);
    model_step(s, p, c, im, is);
    #1;
    check("model", dut_out(), model_out());
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0;
    bus.start = 1'b0; bus.pause = 1'b0; bus.clear = 1'b0;
    bus.inc_min = 1'b0; bus.inc_sec = 1'b0;
    model_reset();

    //               s  p  c  im is   mm ss st fin
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0, 1'b0}; // start at 00:00 ignored
    tbl[1]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1, 0, 0, 1'b0};
    tbl[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1, 1, 0, 1'b0};
    tbl[3]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2, 2, 0, 1'b0}; // both increments apply
    tbl[4]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2, 2, 0, 1'b0}; // pause drops inc
    tbl[5]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2, 2, 1, 1'b0}; // start drops inc
    tbl[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2, 2, 1, 1'b0};
    tbl[7]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2, 2, 0, 1'b0}; // clear beats start
    tbl[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2, 3, 0, 1'b0};
    tbl[9]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2, 3, 1, 1'b0};
    tbl[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2, 3, 1, 1'b0};
    tbl[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2, 3, 1, 1'b0};
    tbl[12] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2, 3, 1, 1'b0};
    tbl[13] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2, 2, 1, 1'b0}; // first tick, 4 edges after start
    tbl[14] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2, 2, 2, 1'b0};
    tbl[15] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2, 2, 2, 1'b0};
    tbl[16] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2, 2, 1, 1'b0}; // start resumes
    tbl[17] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2, 3, 0, 1'b0}; // clear shows preset

    idle(3);
    #1 rst_n = 1'b1;
    idle(3);
    check("reset_state", dut_out(), pack(0, 0, 0, 1'b0));

    for (int i = 0; i < 18; i++) begin
      cyc(tbl[i].s, tbl[i].p, tbl[i].c, tbl[i].im, tbl[i].is);
      check($sformatf("vec%0d", i), dut_out(), pack(tbl[i].mm, tbl[i].ss, tbl[i].st, tbl[i].fin));
    end

    // Preset 02:03 -> 12:34, run, then assert reset between clock edges.
    for (int i = 0; i < 10; i++) cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 21; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("preset_1234", dut_out(), pack(12, 34, 0, 1'b0));
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(2);
    check("run_1234", dut_out(), pack(12, 34, 1, 1'b0));
    #2 rst_n = 1'b0;
    #1 check("async_reset", dut_out(), pack(0, 0, 0, 1'b0));
    model_reset();
    idle(2);
    #1 rst_n = 1'b1;
    idle(3);

    // Seconds wrap with no carry into minutes.
    for (int i = 0; i < 60; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("sec_wrap60", dut_out(), pack(0, 0, 0, 1'b0));
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("sec_wrap61", dut_out(), pack(0, 1, 0, 1'b0));
    for (int i = 0; i < 59; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("preset_0100", dut_out(), pack(1, 0, 0, 1'b0));

    // Full countdown of 01:00.
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(4);
    check("first_tick", dut_out(), pack(0, 59, 1, 1'b0));
    idle(235);
    check("pre_done", dut_out(), pack(0, 1, 1, 1'b0));
    idle(1);
    check("done", dut_out(), pack(0, 0, 3, 1'b1));
    idle(5);
    check("done_hold", dut_out(), pack(0, 0, 3, 1'b1));
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("restart_done", dut_out(), pack(1, 0, 1, 1'b0));
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    check("clear_run", dut_out(), pack(1, 0, 0, 1'b0));

    // Borrow through three digits.
    for (int i = 0; i < 9; i++) cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("preset_1000", dut_out(), pack(10, 0, 0, 1'b0));
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(4);
    check("borrow", dut_out(), pack(9, 59, 1, 1'b0));

    // Pause two cycles into a second, hold, resume: decrement two cycles after resume.
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(1);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(20);
    check("pause_frozen", dut_out(), pack(10, 0, 2, 1'b0));
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(1);
    check("resume_plus1", dut_out(), pack(10, 0, 1, 1'b0));
    idle(1);
    check("resume_plus2", dut_out(), pack(9, 59, 1, 1'b0));
    idle(3);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check("tick_pause", dut_out(), pack(9, 58, 2, 1'b0));
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

    // Random requests against the model.
    for (int i = 0; i < 4000; i++) begin
      cyc($urandom_range(0, 15) == 0, $urandom_range(0, 15) == 0, $urandom_range(0, 63) == 0,
          $urandom_range(0, 31) == 0, $urandom_range(0, 3) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
